// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host receiver: synchronises and filters kclk/kdata, deframes
// 11-bit frames, and folds E0/F0 prefixes into one make/break event per key.
module ps2_frame_rx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT_US = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        kclk,
  input  logic        kdata,
  output logic        code_valid,
  output logic [7:0]  code,
  output logic        is_break,
  output logic        is_ext,
  output logic [31:0] keycode_hist,
  output logic        frame_err
);

  localparam int TO_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TO_W      = $clog2(TO_CYCLES + 1);
  localparam int FLT_W     = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Index 0 carries kclk, index 1 carries kdata.
  logic [1:0]       sync1, sync2, filt;
  logic [FLT_W-1:0] flt_cnt [2];
  logic             kclk_prev;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 2'b11;
      sync2     <= 2'b11;
      filt      <= 2'b11;
      kclk_prev <= 1'b1;
      for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
    end else begin
      sync1     <= {kdata, kclk};
      sync2     <= sync1;
      kclk_prev <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == FLT_W'(FILTER_LEN - 1)) begin
          filt[i]    <= sync2[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + FLT_W'(1);
        end
      end
    end
  end

  logic fall, rx_bit, frame_good;
  assign fall   = kclk_prev & ~filt[0];
  assign rx_bit = filt[1];

  state_t          state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            par_bit;
  logic [TO_W-1:0] to_cnt;
  logic            ext_flag, brk_flag;

  // Odd parity across data plus parity bit, and the stop bit must be high.
  assign frame_good = rx_bit & (^{shift, par_bit});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift        <= '0;
      par_bit      <= 1'b0;
      to_cnt       <= '0;
      ext_flag     <= 1'b0;
      brk_flag     <= 1'b0;
      code_valid   <= 1'b0;
      code         <= '0;
      is_break     <= 1'b0;
      is_ext       <= 1'b0;
      keycode_hist <= '0;
      frame_err    <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        case (state)
          IDLE: begin
            if (!rx_bit) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift   <= {rx_bit, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= rx_bit;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (frame_good) begin
              keycode_hist <= {keycode_hist[23:0], shift};
              if (shift == 8'hE0) begin
                ext_flag <= 1'b1;
              end else if (shift == 8'hF0) begin
                brk_flag <= 1'b1;
              end else begin
                code       <= shift;
                is_break   <= brk_flag;
                is_ext     <= ext_flag;
                code_valid <= 1'b1;
                ext_flag   <= 1'b0;
                brk_flag   <= 1'b0;
              end
            end else begin
              frame_err <= 1'b1;
              ext_flag  <= 1'b0;
              brk_flag  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // A stalled frame is abandoned; an edge in the same cycle takes priority.
        if (to_cnt == TO_W'(TO_CYCLES - 1)) begin
          state     <= IDLE;
          to_cnt    <= '0;
          frame_err <= 1'b1;
          ext_flag  <= 1'b0;
          brk_flag  <= 1'b0;
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: frames are bit-banged on kclk/kdata and
// expected events are queued, then matched when the DUT strobes.
`timescale 1ns/1ps
module tb_ps2_frame_rx;

  // One clock per microsecond keeps the 200 us timeout at 200 cycles.
  localparam int CLK_HZ     = 1_000_000;
  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT_US = 200;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        kclk  = 1'b1;
  logic        kdata = 1'b1;
  logic        code_valid, is_break, is_ext, frame_err;
  logic [7:0]  code;
  logic [31:0] keycode_hist;

  ps2_frame_rx #(
    .CLK_HZ    (CLK_HZ),
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .kclk        (kclk),
    .kdata       (kdata),
    .code_valid  (code_valid),
    .code        (code),
    .is_break    (is_break),
    .is_ext      (is_ext),
    .keycode_hist(keycode_hist),
    .frame_err   (frame_err)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic [7:0]  code;
    logic        brk;
    logic        ext;
    logic [31:0] hist;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard side: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (code_valid || frame_err)) begin
      check("strobe_exclusive", {31'b0, code_valid & frame_err}, 32'd0);
      if (exp_q.size() == 0) begin
        check("spurious_strobe", {30'b0, frame_err, code_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", {31'b0, frame_err}, {31'b0, e.is_err});
        check("keycode_hist", keycode_hist, e.hist);
        if (!e.is_err) begin
          check("code", {24'b0, code}, {24'b0, e.code});
          check("is_break", {31'b0, is_break}, {31'b0, e.brk});
          check("is_ext", {31'b0, is_ext}, {31'b0, e.ext});
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_evt(input logic [7:0] c, input logic brk, input logic ext,
                            input logic [31:0] hist);
    exp_t e;
    e.is_err = 1'b0; e.code = c; e.brk = brk; e.ext = ext; e.hist = hist;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input logic [31:0] hist);
    exp_t e;
    e.is_err = 1'b1; e.code = '0; e.brk = 1'b0; e.ext = 1'b0; e.hist = hist;
    exp_q.push_back(e);
  endtask

  // 70-cycle bit: data set while kclk high, falling edge, low phase, high phase.
  // A glitch is a (FILTER_LEN-1)-cycle low pulse on kclk in the trailing high phase.
  task automatic ps2_bit(input logic b, input logic glitch);
    kdata = b;
    wait_cyc(20);
    kclk = 1'b0;
    wait_cyc(30);
    kclk = 1'b1;
    if (glitch) begin
      wait_cyc(8);
      kclk = 1'b0;
      wait_cyc(FILTER_LEN - 1);
      kclk = 1'b1;
      wait_cyc(20 - 8 - (FILTER_LEN - 1));
    end else begin
      wait_cyc(20);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                            input logic glitch);
    logic [7:0] d;
    d = b;
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], glitch);
    ps2_bit((~^d) ^ bad_par, glitch);
    ps2_bit(~bad_stop, glitch);
    kdata = 1'b1;
    wait_cyc(40);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    logic [7:0] d;
    d = b;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(d[i], 1'b0);
    kdata = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_code_valid"}, {31'b0, code_valid}, 32'd0);
    check({tag, "_code"}, {24'b0, code}, 32'd0);
    check({tag, "_is_break"}, {31'b0, is_break}, 32'd0);
    check({tag, "_is_ext"}, {31'b0, is_ext}, 32'd0);
    check({tag, "_hist"}, keycode_hist, 32'd0);
    check({tag, "_frame_err"}, {31'b0, frame_err}, 32'd0);
  endtask

  task automatic drained(input string tag);
    wait_cyc(50);
    check(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    wait_cyc(2);
    check_reset_state("in_reset");
    rst_n = 1'b1;
    wait_cyc(5);
    check_reset_state("after_reset");

    // Plain make code.
    expect_evt(8'h1C, 1'b0, 1'b0, 32'h0000_001C);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    drained("t1_drained");

    // Break: F0 1C.
    do_reset();
    expect_evt(8'h1C, 1'b1, 1'b0, 32'h0000_F01C);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    drained("t2_drained");

    // Extended break E0 F0 75, then a plain 75 with flags cleared.
    do_reset();
    expect_evt(8'h75, 1'b1, 1'b1, 32'h00E0_F075);
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0, 1'b0);
    expect_evt(8'h75, 1'b0, 1'b0, 32'hE0F0_7575);
    send_frame(8'h75, 1'b0, 1'b0, 1'b0);
    drained("t3_drained");

    // Bad parity after F0 drops the prefix; bad stop bit also rejected.
    do_reset();
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    expect_err(32'h0000_00F0);
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    check("t4_code_held", {24'b0, code}, 32'd0);
    expect_evt(8'h1C, 1'b0, 1'b0, 32'h0000_F01C);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    expect_err(32'h0000_F01C);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("t4_code_hold_after_err", {24'b0, code}, 32'h1C);
    drained("t4_drained");

    // Timeout after start + 5 data bits, then a clean frame.
    do_reset();
    expect_err(32'h0000_0000);
    send_partial(8'h16, 5);
    wait_cyc(TIMEOUT_US + 100);
    check("t5_timeout_seen", exp_q.size(), 32'd0);
    expect_evt(8'h16, 1'b0, 1'b0, 32'h0000_0016);
    send_frame(8'h16, 1'b0, 1'b0, 1'b0);
    drained("t5_drained");

    // Mid-frame reset clears everything; short glitches are filtered out.
    do_reset();
    expect_evt(8'h2A, 1'b0, 1'b0, 32'h0000_002A);
    send_frame(8'h2A, 1'b0, 1'b0, 1'b0);
    send_partial(8'h1C, 3);
    do_reset();
    check_reset_state("t6_midframe");
    kclk = 1'b0;
    wait_cyc(FILTER_LEN - 1);
    kclk = 1'b1;
    kdata = 1'b0;
    wait_cyc(FILTER_LEN - 1);
    kdata = 1'b1;
    wait_cyc(20);
    expect_evt(8'h1C, 1'b0, 1'b0, 32'h0000_001C);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
    drained("t6_drained");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
